regfile_wr_arbiter: RTL and testbench

//  Sole owner of the 8x16-bit register file write port (wDest/wDat/regWrt).

---
 rtl/regfile_wr_arbiter.sv | 96 +++++++++
 tb/tb_regfile_wr_arbiter.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/regfile_wr_arbiter.sv
// Write-port owner for the 8x16 register file: clears every register after reset,
// then round-robin arbitrates writeback requesters onto the single write port.
module regfile_wr_arbiter #(
  parameter int NREQ       = 3,
  parameter int DW         = 16,
  parameter int AW         = 3,
  parameter bit INIT_CLEAR = 1'b1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               stall,
  input  logic [NREQ-1:0]    req_valid,
  input  logic [NREQ*AW-1:0] req_dest,
  input  logic [NREQ*DW-1:0] req_data,
  output logic [NREQ-1:0]    req_ready,
  output logic [AW-1:0]      wDest,
  output logic [DW-1:0]      wDat,
  output logic               regWrt,
  output logic [1:0]         grant_id,
  output logic               init_done
);

  typedef enum logic {INIT, RUN} state_t;

  localparam state_t RESET_STATE = INIT_CLEAR ? INIT : RUN;

  state_t        state, stateNext;
  logic [AW-1:0] cnt;
  logic [1:0]    ptr;
  logic          gntFound;
  logic [1:0]    gntIdx;
  logic [AW-1:0] gntDest;
  logic [DW-1:0] gntData;
  int            idx;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= RESET_STATE;
    else        state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    if (state == INIT && cnt == '1) stateNext = RUN;
  end

  // Rotating priority search starting at ptr; reset gating keeps req_ready low
  // even when the block comes out of reset directly in RUN.
  always_comb begin
    req_ready = '0;
    gntFound  = 1'b0;
    gntIdx    = '0;
    gntDest   = '0;
    gntData   = '0;
    idx       = 0;
    if (reset && state == RUN && !stall) begin
      for (int k = 0; k < NREQ; k++) begin
        idx = int'(ptr) + k;
        if (idx >= NREQ) idx = idx - NREQ;
        if (!gntFound && req_valid[idx]) begin
          gntFound       = 1'b1;
          gntIdx         = 2'(idx);
          gntDest        = req_dest[AW*idx +: AW];
          gntData        = req_data[DW*idx +: DW];
          req_ready[idx] = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt      <= '0;
      ptr      <= '0;
      wDest    <= '0;
      wDat     <= '0;
      regWrt   <= 1'b0;
      grant_id <= '0;
    end else if (state == INIT) begin
      wDest  <= cnt;
      wDat   <= '0;
      regWrt <= 1'b1;
      cnt    <= cnt + 1'b1;
    end else if (gntFound) begin
      wDest    <= gntDest;
      wDat     <= gntData;
      regWrt   <= 1'b1;
      grant_id <= gntIdx;
      ptr      <= (gntIdx == 2'(NREQ - 1)) ? 2'd0 : gntIdx + 2'd1;
    end else begin
      regWrt <= 1'b0;
    end
  end

  assign init_done = (state == RUN);

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Directed bench for regfile_wr_arbiter: clear sequence, single and rotating grants,
// stall, same-destination ordering and reset in the middle of the clear.
module tb_regfile_wr_arbiter;

  localparam int NREQ = 3;
  localparam int DW   = 16;
  localparam int AW   = 3;

  logic               clk = 1'b0;
  logic               reset;
  logic               stall;
  logic [NREQ-1:0]    req_valid;
  logic [NREQ*AW-1:0] req_dest;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0]    req_ready;
  logic [AW-1:0]      wDest;
  logic [DW-1:0]      wDat;
  logic               regWrt;
  logic [1:0]         grant_id;
  logic               init_done;

  int errors = 0;
  int checks = 0;

  regfile_wr_arbiter #(.NREQ(NREQ), .DW(DW), .AW(AW), .INIT_CLEAR(1'b1)) dut (
    .clk(clk), .reset(reset), .stall(stall),
    .req_valid(req_valid), .req_dest(req_dest), .req_data(req_data),
    .req_ready(req_ready), .wDest(wDest), .wDat(wDat), .regWrt(regWrt),
    .grant_id(grant_id), .init_done(init_done)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [NREQ-1:0] v, input logic s);
    req_valid = v;
    stall     = s;
  endtask

  task automatic setReq(input int i, input logic [AW-1:0] d, input logic [DW-1:0] x);
    req_dest[AW*i +: AW] = d;
    req_data[DW*i +: DW] = x;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset     = 1'b0;
    stall     = 1'b0;
    req_valid = '0;
    req_dest  = '0;
    req_data  = '0;
    @(negedge clk);
    @(negedge clk);
    checkOutput("rst_regWrt", 32'(regWrt), 32'd0);
    checkOutput("rst_wDest", 32'(wDest), 32'd0);
    checkOutput("rst_init_done", 32'(init_done), 32'd0);
    checkOutput("rst_req_ready", 32'(req_ready), 32'd0);
    reset = 1'b1;

    // Clear sequence: 8 pulses to 0..7 with data 0, requests ignored
    applyStimulus(3'b111, 1'b0);
    for (int k = 0; k < 8; k++) begin
      if (k == 7) applyStimulus(3'b000, 1'b0);
      tick();
      checkOutput($sformatf("init_regWrt_%0d", k), 32'(regWrt), 32'd1);
      checkOutput($sformatf("init_wDest_%0d", k), 32'(wDest), 32'(k));
      checkOutput($sformatf("init_wDat_%0d", k), 32'(wDat), 32'd0);
      checkOutput($sformatf("init_done_%0d", k), 32'(init_done), (k == 7) ? 32'd1 : 32'd0);
      if (k < 7) checkOutput($sformatf("init_ready_%0d", k), 32'(req_ready), 32'd0);
    end
    tick();
    checkOutput("idle_regWrt", 32'(regWrt), 32'd0);

    // Single requester 1
    setReq(1, 3'd5, 16'hBEEF);
    applyStimulus(3'b010, 1'b0);
    #1;
    checkOutput("t2_ready", 32'(req_ready), 32'b010);
    tick();
    applyStimulus(3'b000, 1'b0);
    checkOutput("t2_regWrt", 32'(regWrt), 32'd1);
    checkOutput("t2_wDest", 32'(wDest), 32'd5);
    checkOutput("t2_wDat", 32'(wDat), 32'hBEEF);
    checkOutput("t2_grant", 32'(grant_id), 32'd1);

    // ptr is now 2; one grant to requester 2 brings it back to 0
    setReq(2, 3'd6, 16'h2222);
    applyStimulus(3'b100, 1'b0);
    tick();
    checkOutput("t3pre_grant", 32'(grant_id), 32'd2);
    checkOutput("t3pre_wDat", 32'(wDat), 32'h2222);

    // All valid: grants rotate 0,1,2,0,1,2 with continuous regWrt
    setReq(0, 3'd1, 16'h0A0A);
    applyStimulus(3'b111, 1'b0);
    for (int k = 0; k < 6; k++) begin
      tick();
      checkOutput($sformatf("t3_grant_%0d", k), 32'(grant_id), 32'(k % 3));
      checkOutput($sformatf("t3_regWrt_%0d", k), 32'(regWrt), 32'd1);
    end

    // Stall with req0 and req2 valid
    applyStimulus(3'b101, 1'b1);
    for (int k = 0; k < 3; k++) begin
      #1;
      checkOutput($sformatf("t4_ready_%0d", k), 32'(req_ready), 32'd0);
      tick();
      checkOutput($sformatf("t4_regWrt_%0d", k), 32'(regWrt), 32'd0);
    end
    applyStimulus(3'b101, 1'b0);
    #1;
    checkOutput("t4_ready0", 32'(req_ready), 32'b001);
    tick();
    checkOutput("t4_grant0", 32'(grant_id), 32'd0);
    checkOutput("t4_regWrt0", 32'(regWrt), 32'd1);
    applyStimulus(3'b100, 1'b0);
    #1;
    checkOutput("t4_ready2", 32'(req_ready), 32'b100);
    tick();
    checkOutput("t4_grant2", 32'(grant_id), 32'd2);
    checkOutput("t4_wDat2", 32'(wDat), 32'h2222);

    // Same destination from requesters 0 and 1, ptr = 0
    setReq(0, 3'd3, 16'd1);
    setReq(1, 3'd3, 16'd2);
    applyStimulus(3'b011, 1'b0);
    tick();
    checkOutput("t6_first_wDest", 32'(wDest), 32'd3);
    checkOutput("t6_first_wDat", 32'(wDat), 32'd1);
    applyStimulus(3'b010, 1'b0);
    tick();
    checkOutput("t6_second_wDat", 32'(wDat), 32'd2);
    checkOutput("t6_second_grant", 32'(grant_id), 32'd1);
    applyStimulus(3'b000, 1'b0);
    tick();
    checkOutput("t6_idle", 32'(regWrt), 32'd0);

    // Reset during the clear at cnt = 4
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    for (int k = 0; k < 4; k++) tick();
    checkOutput("t5_pre_wDest", 32'(wDest), 32'd3);
    reset = 1'b0;
    #1;
    checkOutput("t5_rst_regWrt", 32'(regWrt), 32'd0);
    checkOutput("t5_rst_wDest", 32'(wDest), 32'd0);
    checkOutput("t5_rst_grant", 32'(grant_id), 32'd0);
    checkOutput("t5_rst_init_done", 32'(init_done), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    tick();
    checkOutput("t5_restart_regWrt", 32'(regWrt), 32'd1);
    checkOutput("t5_restart_wDest", 32'(wDest), 32'd0);
    tick();
    checkOutput("t5_restart_wDest1", 32'(wDest), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
